// File: rtl/sprite_oam_dma_if.sv
// AHB-Lite bus bundle for the sprite OAM DMA path.
// The master drives address and control; the slave returns ready, data and response.
interface sprite_oam_dma_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HSIZE, HBURST,
    output HPROT, HWRITE, HWDATA,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HBURST,
    input  HPROT, HWRITE, HWDATA,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/sprite_oam_dma.sv
// AHB-Lite read DMA that refills the sprite RAM from a table in system memory.
// Address and data phases are pipelined; an ERROR response aborts the copy.
module sprite_oam_dma #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  start,
  input  logic [31:0]           src_base,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE,
  sprite_oam_dma_if.master      bus
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE  =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_STREAM, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t                state;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic [ADDR_WIDTH-1:0] abeat;
  logic [ADDR_WIDTH-1:0] dbeat;
  logic                  dvalid;
  logic [31:0]           next_addr;
  logic                  unused_ok;

  assign next_addr  = haddr + 32'd4;
  assign unused_ok  = ^src_base[1:0];

  assign bus.HADDR  = haddr;
  assign bus.HTRANS = htrans;
  assign bus.HSIZE  = 3'b010;
  assign bus.HBURST = 3'b001;
  assign bus.HPROT  = 4'b0011;
  assign bus.HWRITE = 1'b0;
  assign bus.HWDATA = 32'd0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      haddr       <= '0;
      htrans      <= T_IDLE;
      abeat       <= '0;
      dbeat       <= '0;
      dvalid      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      BRAM_WRADDR <= '0;
      BRAM_WDATA  <= '0;
      BRAM_WRITE  <= '0;
    end else begin
      BRAM_WRITE <= '0;
      done       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            haddr  <= {src_base[31:2], 2'b00};
            htrans <= T_NONSEQ;
            abeat  <= '0;
            dbeat  <= '0;
            dvalid <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= S_ADDR;
          end
        end
        S_ADDR, S_STREAM, S_DRAIN: begin
          // First cycle of a two-cycle ERROR: cancel the pending address
          if (dvalid && bus.HRESP && !bus.HREADY) begin
            htrans <= T_IDLE;
            err    <= 1'b1;
            dvalid <= 1'b0;
            state  <= S_ERR;
          end else if (bus.HREADY) begin
            if (dvalid && !bus.HRESP) begin
              BRAM_WRITE  <= 4'hF;
              BRAM_WRADDR <= dbeat;
              BRAM_WDATA  <= bus.HRDATA;
            end
            if (htrans != T_IDLE) begin
              dvalid <= 1'b1;
              dbeat  <= abeat;
              if (abeat == LAST) begin
                htrans <= T_IDLE;
                state  <= S_DRAIN;
              end else begin
                abeat  <= abeat + ONE;
                haddr  <= next_addr;
                // INCR bursts restart at each 1KB boundary
                htrans <= (next_addr[9:0] == 10'd0) ?
                          T_NONSEQ : T_SEQ;
                state  <= S_STREAM;
              end
            end else begin
              dvalid <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_ERR: begin
          if (bus.HREADY) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_oam_dma.sv
// Randomized bench for sprite_oam_dma: AHB slave memory model plus
// a table-level reference of what the sprite RAM must hold afterwards.
module tb_sprite_oam_dma;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_base = '0;
  logic        busy, done, err;
  logic [5:0]  BRAM_WRADDR;
  logic [31:0] BRAM_WDATA;
  logic [3:0]  BRAM_WRITE;

  sprite_oam_dma_if bus();

  sprite_oam_dma #(.ADDR_WIDTH(6)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .src_base(src_base), .busy(busy), .done(done), .err(err),
    .BRAM_WRADDR(BRAM_WRADDR), .BRAM_WDATA(BRAM_WDATA),
    .BRAM_WRITE(BRAM_WRITE), .bus(bus)
  );

  always #10 HCLK = ~HCLK;

  int vectors = 0;
  int miscompares = 0;

  // slave / memory model state
  logic [31:0] xbase = '0;
  logic [31:0] salt = '0;
  int          max_wait = 0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  bit          pend = 1'b0;
  logic [31:0] paddr = '0;
  int          wait_left = 0;
  int          err_ph = 0;

  // observation
  logic [31:0] exp_addr = '0;
  int          addr_bad = 0;
  logic [31:0] ns_q[$];
  logic [31:0] ram_obs[64];
  int          hits[64];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          bad_we = 0;
  int          stab_bad = 0;
  bit          pv = 1'b0;
  logic        p_ready, p_resp;
  logic [31:0] p_addr;
  logic [1:0]  p_trans;

  // results of the last transfer
  int r_done_cyc, r_first_wr;
  logic r_busy1, r_err1, r_done_busy;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (32'hA500_0000 | ((a - xbase) >> 2)) ^ salt;
  endfunction

  function automatic logic [31:0] ref_word(input int i);
    return (32'hA500_0000 | i) ^ salt;
  endfunction

  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend = 1'b0;
      err_ph = 0;
      bus.HREADY = 1'b1;
      bus.HRESP = 1'b0;
    end else begin
      if (bus.HREADY) begin
        if (bus.HTRANS[1]) begin
          if (bus.HADDR !== exp_addr) addr_bad++;
          exp_addr = exp_addr + 32'd4;
          if (bus.HTRANS == 2'b10) ns_q.push_back(bus.HADDR);
          pend = 1'b1;
          paddr = bus.HADDR;
          wait_left = $urandom_range(0, max_wait);
          err_ph = 0;
        end else begin
          pend = 1'b0;
        end
      end
      #1;
      if (!pend) begin
        bus.HREADY = 1'b1;
        bus.HRESP = 1'b0;
        bus.HRDATA = $urandom;
      end else if (err_en && paddr == err_addr) begin
        bus.HRESP = 1'b1;
        bus.HREADY = (err_ph != 0);
        err_ph = 1;
      end else if (wait_left > 0) begin
        bus.HREADY = 1'b0;
        bus.HRESP = 1'b0;
        bus.HRDATA = $urandom;
        wait_left--;
      end else begin
        bus.HREADY = 1'b1;
        bus.HRESP = 1'b0;
        bus.HRDATA = mem_word(paddr);
      end
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (BRAM_WRITE != 4'h0) begin
        if (BRAM_WRITE != 4'hF) bad_we++;
        ram_obs[BRAM_WRADDR] = BRAM_WDATA;
        hits[BRAM_WRADDR]++;
        wr_cnt++;
      end
      if (done) done_cnt++;
      if (pv && !p_ready && !p_resp &&
          (bus.HADDR !== p_addr || bus.HTRANS !== p_trans))
        stab_bad++;
      pv = 1'b1;
      p_ready = bus.HREADY;
      p_resp = bus.HRESP;
      p_addr = bus.HADDR;
      p_trans = bus.HTRANS;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) begin
      ram_obs[i] = 'x;
      hits[i] = 0;
    end
    ns_q.delete();
    wr_cnt = 0;
    done_cnt = 0;
    bad_we = 0;
    stab_bad = 0;
    addr_bad = 0;
  endtask

  // Run one transfer; optionally re-pulse start mid-way and on done.
  task automatic run_xfer(input logic [31:0] base, input int maxw,
                          input bit eon, input int ebeat,
                          input int restart_at, input bit on_done);
    bit restarted;
    restarted = 1'b0;
    clear_obs();
    xbase = {base[31:2], 2'b00};
    max_wait = maxw;
    err_en = eon;
    err_addr = xbase + 32'(4 * ebeat);
    exp_addr = xbase;
    r_done_cyc = -1;
    r_first_wr = -1;
    @(negedge HCLK);
    src_base = base;
    start = 1'b1;
    @(posedge HCLK);
    for (int n = 1; n <= 3000; n++) begin
      @(negedge HCLK);
      start = 1'b0;
      if (n == 1) begin
        r_busy1 = busy;
        r_err1 = err;
      end
      if (r_first_wr < 0 && BRAM_WRITE != 4'h0) r_first_wr = n;
      if (done) begin
        r_done_cyc = n;
        r_done_busy = busy;
        if (on_done) start = 1'b1;
        break;
      end
      if (restart_at >= 0 && !restarted && wr_cnt == restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      @(posedge HCLK);
    end
    repeat (4) begin
      @(negedge HCLK);
      start = 1'b0;
    end
    vectors++;
    if (r_done_cyc < 0) begin
      miscompares++;
      $display("FAIL timeout: done never seen, want a done pulse");
    end
  endtask

  task automatic check_table(input string tag, input int n_ok);
    vectors++;
    if (wr_cnt !== n_ok) begin
      miscompares++;
      $display("FAIL %s_wr_cnt: got %0d want %0d", tag, wr_cnt, n_ok);
    end
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (i < n_ok && (ram_obs[i] !== ref_word(i) || hits[i] != 1)) begin
        miscompares++;
        $display("FAIL %s_ram[%0d]: got %h x%0d want %h x1",
                 tag, i, ram_obs[i], hits[i], ref_word(i));
      end else if (i >= n_ok && hits[i] != 0) begin
        miscompares++;
        $display("FAIL %s_ram[%0d]: got %0d writes want 0", tag, i, hits[i]);
      end
    end
    vectors++;
    if (bad_we != 0 || stab_bad != 0 || addr_bad != 0) begin
      miscompares++;
      $display("FAIL %s_bus: got we=%0d stab=%0d addr=%0d want 0 0 0",
               tag, bad_we, stab_bad, addr_bad);
    end
  endtask

  task automatic check_nonseq(input string tag, input logic [31:0] base,
                              input int n_beats);
    logic [31:0] expq[$];
    logic [31:0] a;
    for (int i = 0; i < n_beats; i++) begin
      a = base + 32'(4 * i);
      if (i == 0 || a[9:0] == 10'd0) expq.push_back(a);
    end
    vectors++;
    if (ns_q.size() != expq.size()) begin
      miscompares++;
      $display("FAIL %s_nonseq_cnt: got %0d want %0d",
               tag, ns_q.size(), expq.size());
    end else begin
      foreach (expq[k]) begin
        vectors++;
        if (ns_q[k] !== expq[k]) begin
          miscompares++;
          $display("FAIL %s_nonseq[%0d]: got %h want %h",
                   tag, k, ns_q[k], expq[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge HCLK);
    vectors++;
    if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_bus: got %b %h want 00 0", bus.HTRANS, bus.HADDR);
    end
    vectors++;
    if ({busy, done, err} !== 3'b000 || BRAM_WRITE !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_ctl: got %b %h want 000 0",
               {busy, done, err}, BRAM_WRITE);
    end
    vectors++;
    if (BRAM_WRADDR !== 6'd0 || BRAM_WDATA !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_bram: got %h %h want 0 0", BRAM_WRADDR, BRAM_WDATA);
    end
    vectors++;
    if (bus.HSIZE !== 3'b010 || bus.HBURST !== 3'b001 ||
        bus.HPROT !== 4'b0011 || bus.HWRITE !== 1'b0 ||
        bus.HWDATA !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_const: got %b %b %b %b %h want 010 001 0011 0 0",
               bus.HSIZE, bus.HBURST, bus.HPROT, bus.HWRITE, bus.HWDATA);
    end
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic test_basic();
    salt = '0;
    run_xfer(32'h2000_0000, 0, 1'b0, 0, -1, 1'b0);
    check_table("basic", 64);
    check_nonseq("basic", 32'h2000_0000, 64);
    vectors++;
    if (r_done_cyc != 66 || r_first_wr != 3) begin
      miscompares++;
      $display("FAIL basic_latency: got done=%0d wr=%0d want 66 3",
               r_done_cyc, r_first_wr);
    end
    vectors++;
    if (r_busy1 !== 1'b1 || r_done_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy: got %b %b want 1 0", r_busy1, r_done_busy);
    end
    vectors++;
    if (err !== 1'b0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL basic_done: got err=%b dones=%0d want 0 1",
               err, done_cnt);
    end
  endtask

  task automatic test_wait_states();
    salt = '0;
    run_xfer(32'h2000_0000, 3, 1'b0, 0, -1, 1'b0);
    check_table("wait", 64);
    check_nonseq("wait", 32'h2000_0000, 64);
    vectors++;
    if (done_cnt != 1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_done: got dones=%0d err=%b want 1 0",
               done_cnt, err);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] b;
    salt = $urandom;
    run_xfer(32'h2000_03C0, 1, 1'b0, 0, -1, 1'b0);
    check_table("bnd", 64);
    check_nonseq("bnd", 32'h2000_03C0, 64);
    for (int t = 0; t < 3; t++) begin
      b = $urandom;
      if (t == 2) b = 32'hFFFF_FF83;
      salt = $urandom;
      run_xfer(b, 2, 1'b0, 0, -1, 1'b0);
      check_table("rnd", 64);
      check_nonseq("rnd", {b[31:2], 2'b00}, 64);
    end
  endtask

  task automatic test_error();
    salt = $urandom;
    run_xfer(32'h2000_1000, 1, 1'b1, 10, -1, 1'b0);
    check_table("err", 10);
    vectors++;
    if (err !== 1'b1 || done_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_flag: got err=%b dones=%0d busy=%b want 1 1 0",
               err, done_cnt, busy);
    end
    run_xfer(32'h2000_1000, 0, 1'b0, 0, -1, 1'b0);
    check_table("errclr", 64);
    vectors++;
    if (r_err1 !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %b %b want 0 0", r_err1, err);
    end
  endtask

  task automatic test_back_to_back();
    salt = $urandom;
    run_xfer(32'h2000_2000, 0, 1'b0, 0, 20, 1'b1);
    check_table("restart", 64);
    vectors++;
    if (done_cnt != 1 || r_done_cyc != 66) begin
      miscompares++;
      $display("FAIL restart_done: got dones=%0d cyc=%0d want 1 66",
               done_cnt, r_done_cyc);
    end
    vectors++;
    if (busy !== 1'b0 || bus.HTRANS !== 2'b00) begin
      miscompares++;
      $display("FAIL start_in_done: got busy=%b htrans=%b want 0 00",
               busy, bus.HTRANS);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    salt = $urandom;
    clear_obs();
    xbase = 32'h2000_3000;
    max_wait = 1;
    err_en = 1'b0;
    exp_addr = xbase;
    @(negedge HCLK);
    src_base = xbase;
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (wr_cnt == 30) begin
        hit = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rstmid_reach: got %0d writes want 30", wr_cnt);
    end
    HRESETn = 1'b0;
    #1;
    vectors++;
    if (bus.HTRANS !== 2'b00 || busy !== 1'b0 || BRAM_WRITE !== 4'h0) begin
      miscompares++;
      $display("FAIL rstmid: got htrans=%b busy=%b we=%h want 00 0 0",
               bus.HTRANS, busy, BRAM_WRITE);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    run_xfer(32'h2000_3000, 2, 1'b0, 0, -1, 1'b0);
    check_table("after_rst", 64);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_boundary();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
